aes_round_scheduler: RTL and testbench

Top-level sequencer for the AES-128 encryption core. It loads the cipher key into the key-expansion store and waits for expansion to complete. It then runs each plaintext block through initial, 9 middle and final rounds, selecting the matching round key each cycle. It also owns the shared S-box mux (key expansion vs. round datapath) and provides valid/ready handshakes on the key, block and result sides.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_exp_watchdog.sv | 35 +++
 rtl/aes_round_scheduler.sv | 159 +++++++++++++++
 tb/tb_aes_round_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round scheduler.
// Pure declarations; no timing or backpressure of its own.
package aes_pkg;
  localparam int NR          = 10;
  localparam int ROUND_W     = 4;
  localparam int EXP_TIMEOUT = 64;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_READY,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_OUT,
    ST_ERROR
  } state_e;

  localparam logic [1:0] RT_IDLE  = 2'd0;
  localparam logic [1:0] RT_INIT  = 2'd1;
  localparam logic [1:0] RT_MID   = 2'd2;
  localparam logic [1:0] RT_FINAL = 2'd3;
endpackage

// File: rtl/aes_exp_watchdog.sv
// Expansion watchdog: counts enabled cycles, timeout is combinational on the LIMIT-th cycle.
// No backpressure; saturates at LIMIT-1 so it never wraps.
module aes_exp_watchdog #(
  parameter int LIMIT = 64,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         at_limit;

  assign at_limit = (cnt_q == W'(LIMIT - 1));
  assign timeout  = en && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_limit) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/aes_round_scheduler.sv
// AES-128 sequencer: key load/expand, then INIT + NR-1 MID + FINAL rounds; ciphertext valid NR+2 cycles after accept.
// Result held in OUT until out_ready; blk_ready only in READY, so blocks back-pressure for the whole cipher run.
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int NR          = aes_pkg::NR,
  parameter int ROUND_W     = aes_pkg::ROUND_W,
  parameter int EXP_TIMEOUT = aes_pkg::EXP_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_req,
  output logic               key_ready,
  output logic               key_err,
  output logic               load_key,
  output logic               key_mode,
  input  logic               expansion_done,
  output logic               sbox_sel,
  input  logic               blk_valid,
  output logic               blk_ready,
  output logic [ROUND_W-1:0] sel_round,
  output logic               dp_en,
  output logic [1:0]         dp_round_type,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);
  state_e               state_q, state_d;
  logic [ROUND_W-1:0]   rnd_q, rnd_d;
  logic                 key_pend_q, key_pend_d;
  logic                 key_err_q, key_err_d;
  logic                 wd_clr, wd_en, wd_timeout;

  aes_exp_watchdog #(.LIMIT(EXP_TIMEOUT)) u_wd (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .timeout (wd_timeout)
  );

  assign key_err = key_err_q;

  always_comb begin
    state_d       = state_q;
    rnd_d         = rnd_q;
    key_pend_d    = key_pend_q;
    key_err_d     = key_err_q;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;
    key_ready     = 1'b0;
    load_key      = 1'b0;
    key_mode      = 1'b1;
    sbox_sel      = 1'b1;
    blk_ready     = 1'b0;
    sel_round     = '0;
    dp_en         = 1'b0;
    dp_round_type = RT_IDLE;
    out_valid     = 1'b0;
    busy          = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (key_req) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_key = 1'b1;
        key_mode = 1'b0;
        sbox_sel = 1'b0;
        wd_clr   = 1'b1;
        state_d  = ST_EXPAND;
      end
      ST_EXPAND: begin
        key_mode = 1'b0;
        sbox_sel = 1'b0;
        wd_en    = 1'b1;
        // A late done on the timeout cycle still counts as success.
        if (expansion_done) begin
          state_d = ST_READY;
        end else if (wd_timeout) begin
          state_d   = ST_ERROR;
          key_err_d = 1'b1;
        end
      end
      ST_READY: begin
        busy      = 1'b0;
        key_ready = 1'b1;
        blk_ready = 1'b1;
        rnd_d     = '0;
        if (blk_valid) begin
          state_d    = ST_INIT;
          key_pend_d = key_req;
        end else if (key_req) begin
          state_d = ST_LOAD;
        end
      end
      ST_INIT: begin
        sel_round     = rnd_q;
        dp_en         = 1'b1;
        dp_round_type = RT_INIT;
        rnd_d         = ROUND_W'(1);
        key_pend_d    = key_pend_q | key_req;
        state_d       = ST_ROUND;
      end
      ST_ROUND: begin
        sel_round     = rnd_q;
        dp_en         = 1'b1;
        dp_round_type = RT_MID;
        key_pend_d    = key_pend_q | key_req;
        if (rnd_q == ROUND_W'(NR - 1)) begin
          rnd_d   = ROUND_W'(NR);
          state_d = ST_FINAL;
        end else begin
          rnd_d = rnd_q + ROUND_W'(1);
        end
      end
      ST_FINAL: begin
        sel_round     = rnd_q;
        dp_en         = 1'b1;
        dp_round_type = RT_FINAL;
        key_pend_d    = key_pend_q | key_req;
        rnd_d         = '0;
        state_d       = ST_OUT;
      end
      ST_OUT: begin
        out_valid  = 1'b1;
        key_pend_d = key_pend_q | key_req;
        if (out_ready) begin
          key_pend_d = 1'b0;
          state_d    = (key_pend_q || key_req) ? ST_LOAD : ST_READY;
        end
      end
      ST_ERROR: begin
        busy = 1'b0;
        if (key_req) state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_LOAD) key_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rnd_q      <= '0;
      key_pend_q <= 1'b0;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      key_pend_q <= key_pend_d;
      key_err_q  <= key_err_d;
    end
  end
endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed + randomized bench for aes_round_scheduler; expectations come from cycle-offset rules
// (expansion delay, round index k -> round type, stall length, pending key request).
module tb_aes_round_scheduler;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_req, expansion_done, blk_valid, out_ready;
  logic       key_ready, key_err, load_key, key_mode, sbox_sel, blk_ready;
  logic [3:0] sel_round;
  logic       dp_en, out_valid, busy;
  logic [1:0] dp_round_type;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  aes_round_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .key_req        (key_req),
    .key_ready      (key_ready),
    .key_err        (key_err),
    .load_key       (load_key),
    .key_mode       (key_mode),
    .expansion_done (expansion_done),
    .sbox_sel       (sbox_sel),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .sel_round      (sel_round),
    .dp_en          (dp_en),
    .dp_round_type  (dp_round_type),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_key_ready"}, key_ready, 0);
    chk({pfx, "_key_err"}, key_err, 0);
    chk({pfx, "_load_key"}, load_key, 0);
    chk({pfx, "_key_mode"}, key_mode, 1);
    chk({pfx, "_sbox_sel"}, sbox_sel, 1);
    chk({pfx, "_blk_ready"}, blk_ready, 0);
    chk({pfx, "_sel_round"}, sel_round, 0);
    chk({pfx, "_dp_en"}, dp_en, 0);
    chk({pfx, "_dp_round_type"}, dp_round_type, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  // Entered in the LOAD cycle; expansion_done is raised in the d-th EXPAND cycle.
  task automatic expand_to_ready(input int d);
    chk("load_key", load_key, 1);
    chk("load_mode", key_mode, 0);
    chk("load_sbox", sbox_sel, 0);
    chk("load_err", key_err, 0);
    chk("load_kready", key_ready, 0);
    step();
    for (int i = 0; i < d; i++) begin
      chk("exp_load_key", load_key, 0);
      chk("exp_mode", key_mode, 0);
      chk("exp_sbox", sbox_sel, 0);
      chk("exp_kready", key_ready, 0);
      chk("exp_busy", busy, 1);
      if (i == d - 1) expansion_done = 1'b1;
      step();
    end
    expansion_done = 1'b0;
    chk("rdy_key_ready", key_ready, 1);
    chk("rdy_blk_ready", blk_ready, 1);
    chk("rdy_mode", key_mode, 1);
    chk("rdy_sbox", sbox_sel, 1);
    chk("rdy_busy", busy, 0);
  endtask

  task automatic req_key(input int d);
    key_req = 1'b1;
    step();
    key_req = 1'b0;
    expand_to_ready(d);
  endtask

  // From READY: accept one block, optionally raise key_req with the accept or at round index
  // kreq_at (-1 = never), stall the result for 'stall' cycles. Returns whether a reload follows.
  task automatic run_block(input int stall, input int kreq_at, input bit kreq_with_accept,
                           output bit pend);
    logic [1:0] exp_rt;
    blk_valid = 1'b1;
    key_req   = kreq_with_accept;
    step();
    blk_valid = 1'b0;
    key_req   = 1'b0;
    for (int k = 0; k <= NR; k++) begin
      exp_rt = (k == 0) ? RT_INIT : ((k == NR) ? RT_FINAL : RT_MID);
      chk("rnd_sel_round", sel_round, k);
      chk("rnd_type", dp_round_type, exp_rt);
      chk("rnd_dp_en", dp_en, 1);
      chk("rnd_sbox", sbox_sel, 1);
      chk("rnd_mode", key_mode, 1);
      chk("rnd_blk_ready", blk_ready, 0);
      chk("rnd_out_valid", out_valid, 0);
      chk("rnd_busy", busy, 1);
      key_req = (k == kreq_at);
      step();
    end
    key_req = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      chk("out_valid", out_valid, 1);
      chk("out_dp_en", dp_en, 0);
      chk("out_sel_round", sel_round, 0);
      chk("out_blk_ready", blk_ready, 0);
      chk("out_key_ready", key_ready, 0);
      out_ready = (s == stall);
      step();
    end
    out_ready = 1'b0;
    pend = kreq_with_accept || (kreq_at >= 0 && kreq_at <= NR);
    chk("post_out_valid", out_valid, 0);
    if (pend) begin
      chk("post_load_key", load_key, 1);
      chk("post_key_ready", key_ready, 0);
    end else begin
      chk("post_key_ready", key_ready, 1);
      chk("post_blk_ready", blk_ready, 1);
    end
  endtask

  initial begin
    bit pend;
    int stall, kat, r;
    bit kwa;

    reset_n = 1'b0;
    key_req = 1'b0;
    expansion_done = 1'b0;
    blk_valid = 1'b0;
    out_ready = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;
    step();

    blk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("idle_blk_ready", blk_ready, 0);
      chk("idle_dp_en", dp_en, 0);
      chk("idle_busy", busy, 0);
      step();
    end
    blk_valid = 1'b0;

    req_key(11);

    run_block(0, -1, 1'b0, pend);
    run_block(0, -1, 1'b0, pend);
    run_block(5, -1, 1'b0, pend);
    run_block(0, 4, 1'b0, pend);
    if (pend) expand_to_ready(64);
    run_block(2, -1, 1'b1, pend);
    if (pend) expand_to_ready(3);
    req_key(1);

    for (int n = 0; n < 8; n++) begin
      stall = $urandom_range(0, 4);
      r     = $urandom_range(0, NR + 4);
      kat   = (r > NR) ? -1 : r;
      kwa   = ($urandom_range(0, 3) == 0);
      run_block(stall, kat, kwa, pend);
      if (pend) expand_to_ready($urandom_range(1, 64));
    end

    // Expansion never completes: ERROR after EXP_TIMEOUT cycles.
    key_req = 1'b1;
    step();
    key_req = 1'b0;
    chk("to_load_key", load_key, 1);
    step();
    for (int i = 0; i < EXP_TIMEOUT; i++) begin
      chk("to_exp_err", key_err, 0);
      chk("to_exp_busy", busy, 1);
      chk("to_exp_mode", key_mode, 0);
      step();
    end
    chk("err_key_err", key_err, 1);
    chk("err_blk_ready", blk_ready, 0);
    chk("err_key_ready", key_ready, 0);
    chk("err_busy", busy, 0);
    chk("err_mode", key_mode, 1);
    blk_valid = 1'b1;
    step();
    step();
    blk_valid = 1'b0;
    chk("err_hold_key_err", key_err, 1);
    chk("err_hold_dp_en", dp_en, 0);
    req_key(5);

    // Asynchronous reset in round 6.
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst_sel_round", sel_round, 6);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_key_ready", key_ready, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
